// File: rtl/reg_writeback.sv
// Writeback stage: orders ALU and load results in a small FIFO and drains one per cycle into the register file.
// Build option WB_FORWARD_EN: forward pending FIFO results to the read ports; when undefined, flag them busy instead.
module reg_writeback #(
    parameter int W     = 8,
    parameter int D     = 4,
    parameter int DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         AluValid,
    input  logic [D-1:0] AluReg,
    input  logic [W-1:0] AluData,
    input  logic         LoadIssue,
    input  logic [D-1:0] LoadReg,
    input  logic         MemValid,
    input  logic [W-1:0] MemData,
    input  logic [D-1:0] RdAddr1,
    input  logic [D-1:0] RdAddr2,
    input  logic [W-1:0] RdData1,
    input  logic [W-1:0] RdData2,
    output logic [W-1:0] FwdData1,
    output logic [W-1:0] FwdData2,
    output logic         Busy1,
    output logic         Busy2,
    output logic         Stall,
    output logic         WriteEn,
    output logic [D-1:0] WrReg,
    output logic [W-1:0] WrData,
    output logic         Error
);

    // Load FSM states
    //   state  | meaning
    //   S_IDLE | no load outstanding
    //   S_WAIT | one load issued, waiting for MemValid

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_HIGH = (AW+1)'(DEPTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } load_state_t;

    load_state_t   state, state_next;
    logic [D-1:0]  load_reg;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [D-1:0]  reg_q  [DEPTH];
    logic [W-1:0]  data_q [DEPTH];
    logic          error_q;

    logic          stall_int;
    logic          load_push, alu_push, load_accept, pop, err_event;
    logic [AW-1:0] alu_ptr;
    logic [AW-1:0] slot  [DEPTH];
    logic          valid [DEPTH];
    logic          load_busy1, load_busy2;

    always_comb begin
        stall_int   = (count >= CNT_HIGH) | ((state == S_WAIT) & ~MemValid);
        load_push   = (state == S_WAIT) & MemValid;
        alu_push    = AluValid & ~stall_int;
        load_accept = LoadIssue & ~stall_int;
        pop         = (count != '0);
        alu_ptr     = wr_ptr + AW'(load_push);
        err_event   = (AluValid & stall_int) | (LoadIssue & stall_int) |
                      (MemValid & (state == S_IDLE));
        state_next  = state;
        case (state)
            S_IDLE: if (load_accept) state_next = S_WAIT;
            S_WAIT: if (MemValid) state_next = load_accept ? S_WAIT : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            load_reg <= '0;
        end else begin
            state <= state_next;
            if (load_accept) load_reg <= LoadReg;
        end
    end

    // Load data is written ahead of a same-cycle ALU result to keep program order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            error_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (load_push) begin
                reg_q[wr_ptr]  <= load_reg;
                data_q[wr_ptr] <= MemData;
            end
            if (alu_push) begin
                reg_q[alu_ptr]  <= AluReg;
                data_q[alu_ptr] <= AluData;
            end
            wr_ptr  <= wr_ptr + AW'(load_push) + AW'(alu_push);
            rd_ptr  <= rd_ptr + AW'(pop);
            count   <= count + (AW+1)'(load_push) + (AW+1)'(alu_push) - (AW+1)'(pop);
            error_q <= error_q | err_event;
        end
    end

    // slot[i] is the i-th oldest entry; later slots are newer.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot[i]  = rd_ptr + AW'(i);
            valid[i] = ((AW+1)'(i) < count);
        end
    end

    assign Stall      = stall_int;
    assign WriteEn    = pop;
    assign WrReg      = pop ? reg_q[rd_ptr]  : '0;
    assign WrData     = pop ? data_q[rd_ptr] : '0;
    assign Error      = error_q;
    assign load_busy1 = (state == S_WAIT) & (load_reg == RdAddr1);
    assign load_busy2 = (state == S_WAIT) & (load_reg == RdAddr2);

`ifdef WB_FORWARD_EN
    always_comb begin
        FwdData1 = RdData1;
        FwdData2 = RdData2;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (reg_q[slot[i]] == RdAddr1)) FwdData1 = data_q[slot[i]];
            if (valid[i] && (reg_q[slot[i]] == RdAddr2)) FwdData2 = data_q[slot[i]];
        end
        Busy1 = load_busy1;
        Busy2 = load_busy2;
    end
`else
    logic hit1, hit2;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (reg_q[slot[i]] == RdAddr1)) hit1 = 1'b1;
            if (valid[i] && (reg_q[slot[i]] == RdAddr2)) hit2 = 1'b1;
        end
        FwdData1 = RdData1;
        FwdData2 = RdData2;
        Busy1    = load_busy1 | hit1;
        Busy2    = load_busy2 | hit2;
    end
`endif

endmodule
